seven_seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for a common-anode multi-digit 7-segment display.
- Shares one downstream 7-segment decoder among NUM_DIGITS digits. Each digit gets a blanking interval followed by a drive interval.
- Presents that digit's 4-bit nibble and decimal point to the decoder and asserts its active-low digit select.
- Host writes are double-buffered and committed only at frame boundaries, so the display never tears mid-frame.

---
 rtl/seven_seg_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a common-anode multi-digit 7-segment display. Host writes are committed
// only at frame boundaries. Optional macro SEVEN_SEG_LEADING_ZERO_BLANK_EN hides leading zeros.
module seven_seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned DRIVE_CYCLES = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic                    i_CLK,
   input  logic                    i_RST,
   input  logic                    i_ENABLE,
   input  logic                    i_WR_EN,
   input  logic [4*NUM_DIGITS-1:0] i_WR_DATA,
   input  logic [NUM_DIGITS-1:0]   i_WR_DP,
   output logic                    o_WR_READY,
   output logic [3:0]              o_NIBBLE,
   output logic                    o_DP,
   output logic                    o_BLANK,
   output logic [NUM_DIGITS-1:0]   o_DIGIT_SEL,
   output logic                    o_FRAME_DONE
);

   localparam int unsigned MAX_CYCLES = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES
                                                                      : BLANK_CYCLES;
   localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST =
      CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic [4*NUM_DIGITS-1:0] active_data_q, active_data_d;
   logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
   logic [4*NUM_DIGITS-1:0] pend_data_q;
   logic [NUM_DIGITS-1:0]   pend_dp_q;
   logic                    pend_valid_q, pend_valid_d;

   logic                    frame_end;
   logic                    commit;
   logic                    accept;
   logic [3:0]              nib_sel;
   logic                    dp_sel;
   logic                    suppress;
   logic                    drive_d;
   logic [NUM_DIGITS-1:0]   sel_d;
   logic                    frame_done_d;

   // Next-state for the scan sequencer; i_ENABLE low overrides everything.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      if (!i_ENABLE) begin
         state_d = StIdle;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            StIdle: begin
               idx_d   = '0;
               cnt_d   = '0;
               state_d = (BLANK_CYCLES == 0) ? StDrive : StBlank;
            end
            StBlank: begin
               if (cnt_q == BLANK_LAST) begin
                  cnt_d   = '0;
                  state_d = StDrive;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            StDrive: begin
               if (cnt_q == DRIVE_LAST) begin
                  cnt_d   = '0;
                  idx_d   = (idx_q == IDX_LAST) ? '0 : (idx_q + IDX_W'(1));
                  state_d = (BLANK_CYCLES == 0) ? StDrive : StBlank;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = StIdle;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Double buffer: accept and commit are mutually exclusive since ready tracks !pend_valid.
   always_comb begin
      frame_end     = (state_q == StDrive) && (cnt_q == DRIVE_LAST) && (idx_q == IDX_LAST);
      commit        = pend_valid_q && ((state_q == StIdle) || frame_end);
      accept        = i_WR_EN && o_WR_READY;
      active_data_d = commit ? pend_data_q : active_data_q;
      active_dp_d   = commit ? pend_dp_q : active_dp_q;
      pend_valid_d  = accept || (pend_valid_q && !commit);
   end

   always_comb begin
      nib_sel = 4'h0;
      dp_sel  = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_d == IDX_W'(k)) begin
            nib_sel = active_data_d[4*k +: 4];
            dp_sel  = active_dp_d[k];
         end
      end
   end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   // Digit k>0 is hidden when it and every more significant nibble are zero.
   always_comb begin
      logic upper_zero;
      upper_zero = 1'b1;
      suppress   = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         upper_zero = upper_zero && (active_data_d[4*k +: 4] == 4'h0);
         if (idx_d == IDX_W'(k)) begin
            suppress = upper_zero;
         end
      end
   end
`else
   assign suppress = 1'b0;
`endif

   // Outputs are decoded from next-state so the pins line up with the state registers.
   always_comb begin
      drive_d = (state_d == StDrive) && !suppress;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         sel_d[k] = !(drive_d && (idx_d == IDX_W'(k)));
      end
      frame_done_d = (state_d == StDrive) && (idx_d == IDX_LAST) && (cnt_d == DRIVE_LAST);
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q       <= StIdle;
         idx_q         <= '0;
         cnt_q         <= '0;
         active_data_q <= '0;
         active_dp_q   <= '0;
         pend_data_q   <= '0;
         pend_dp_q     <= '0;
         pend_valid_q  <= 1'b0;
         o_WR_READY    <= 1'b1;
         o_NIBBLE      <= 4'h0;
         o_DP          <= 1'b0;
         o_BLANK       <= 1'b1;
         o_DIGIT_SEL   <= '1;
         o_FRAME_DONE  <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         active_data_q <= active_data_d;
         active_dp_q   <= active_dp_d;
         if (accept) begin
            pend_data_q <= i_WR_DATA;
            pend_dp_q   <= i_WR_DP;
         end
         pend_valid_q  <= pend_valid_d;
         o_WR_READY    <= !pend_valid_d;
         o_NIBBLE      <= drive_d ? nib_sel : 4'h0;
         o_DP          <= drive_d && dp_sel;
         o_BLANK       <= !drive_d;
         o_DIGIT_SEL   <= sel_d;
         o_FRAME_DONE  <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: main instance with a 2-cycle blank phase and a second
// instance with no blank phase. Honours SEVEN_SEG_LEADING_ZERO_BLANK_EN when defined.
module tb_seven_seg_scan_ctrl;

   localparam int ND = 4;
   localparam int DC = 4;
   localparam int BC = 2;
   localparam int SLOT  = BC + DC;
   localparam int FRAME = SLOT * ND;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        en0 = 1'b0;
   logic        wr_en = 1'b0;
   logic [15:0] wr_data = 16'h0;
   logic [3:0]  wr_dp = 4'h0;

   logic        rdy, dp, blank, fd;
   logic [3:0]  nib, sel;
   logic        rdy0, dp0, blank0, fd0;
   logic [3:0]  nib0, sel0;

   int total = 0;
   int bad = 0;

   // Reference model of the main instance
   bit          m_run = 1'b0;
   bit          m_pend = 1'b0;
   int          ph = 0;
   logic [15:0] m_shown = 16'h0;
   logic [3:0]  m_sdp = 4'h0;
   logic [15:0] m_pdata = 16'h0;
   logic [3:0]  m_pdp = 4'h0;

   always #5 clk = ~clk;

   seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .DRIVE_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
      .i_CLK(clk), .i_RST(rst), .i_ENABLE(en), .i_WR_EN(wr_en), .i_WR_DATA(wr_data),
      .i_WR_DP(wr_dp), .o_WR_READY(rdy), .o_NIBBLE(nib), .o_DP(dp), .o_BLANK(blank),
      .o_DIGIT_SEL(sel), .o_FRAME_DONE(fd)
   );

   seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .DRIVE_CYCLES(DC), .BLANK_CYCLES(0)) dut0 (
      .i_CLK(clk), .i_RST(rst), .i_ENABLE(en0), .i_WR_EN(wr_en), .i_WR_DATA(wr_data),
      .i_WR_DP(wr_dp), .o_WR_READY(rdy0), .o_NIBBLE(nib0), .o_DP(dp0), .o_BLANK(blank0),
      .o_DIGIT_SEL(sel0), .o_FRAME_DONE(fd0)
   );

   task automatic check(input string tag, input string field, input logic [15:0] obs,
                        input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock of the main instance: advance the model across the edge, then compare.
   task automatic cyc(input string tag);
      bit          e, acc, bnd, idle_commit, drv, sup, efd;
      logic [15:0] d;
      logic [3:0]  p;
      int          dg;
      e = en;
      d = wr_data;
      p = wr_dp;
      acc = wr_en && !m_pend;
      bnd = m_run && (ph % FRAME == FRAME - 1);
      idle_commit = !m_run;
      tick();
      if ((bnd || idle_commit) && m_pend) begin
         m_shown = m_pdata;
         m_sdp = m_pdp;
         m_pend = 1'b0;
      end
      if (acc) begin
         m_pdata = d;
         m_pdp = p;
         m_pend = 1'b1;
      end
      if (!e) begin
         m_run = 1'b0;
         ph = 0;
      end else if (!m_run) begin
         m_run = 1'b1;
         ph = 0;
      end else begin
         ph++;
      end
      drv = 1'b0;
      sup = 1'b0;
      efd = 1'b0;
      dg = 0;
      if (m_run) begin
         dg = (ph / SLOT) % ND;
         drv = (ph % SLOT) >= BC;
         efd = (ph % FRAME) == FRAME - 1;
      end
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (drv && dg > 0 && ((m_shown >> (4 * dg)) == 16'h0)) begin
         drv = 1'b0;
         sup = 1'b1;
      end
`endif
      check(tag, "sel", {12'h0, sel}, drv ? {12'h0, ~(4'b0001 << dg)} : 16'h000f);
      check(tag, "blank", {15'h0, blank}, {15'h0, !drv});
      check(tag, "frame_done", {15'h0, fd}, {15'h0, efd});
      check(tag, "wr_ready", {15'h0, rdy}, {15'h0, !m_pend});
      if (drv) begin
         check(tag, "nibble", {12'h0, nib}, (m_shown >> (4 * dg)) & 16'h000f);
         check(tag, "dp", {15'h0, dp}, {15'h0, m_sdp[dg]});
      end
      if (sup) begin
         check(tag, "dp_hidden", {15'h0, dp}, 16'h0);
      end
   endtask

   initial begin
      // 1. Reset held with enable high
      rst = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst", "sel", {12'h0, sel}, 16'h000f);
         check("rst", "blank", {15'h0, blank}, 16'h1);
         check("rst", "wr_ready", {15'h0, rdy}, 16'h1);
         check("rst", "frame_done", {15'h0, fd}, 16'h0);
         check("rst", "nibble", {12'h0, nib}, 16'h0);
         check("rst", "dp", {15'h0, dp}, 16'h0);
         check("rst0", "sel", {12'h0, sel0}, 16'h000f);
         check("rst0", "wr_ready", {15'h0, rdy0}, 16'h1);
      end
      rst = 1'b0;
      cyc("release");
      en = 1'b0;
      cyc("idle");

      // 2. Write 4321 while idle, then scan two frames
      wr_en = 1'b1;
      wr_data = 16'h4321;
      wr_dp = 4'b0100;
      cyc("wr_idle");
      wr_en = 1'b0;
      cyc("commit_idle");
      en = 1'b1;
      repeat (2 * FRAME) cyc("scan");

      // 3. Mid-frame write during digit 1, plus an ignored second write
      repeat (SLOT + BC + 1) cyc("to_digit1");
      wr_en = 1'b1;
      wr_data = 16'hABCD;
      wr_dp = 4'b0001;
      cyc("wr_mid");
      wr_data = 16'h9999;
      wr_dp = 4'b1111;
      cyc("wr_ignored");
      wr_en = 1'b0;
      repeat (40) cyc("frame_commit");

      // 4. Disable during digit 2 drive, then restart
      while ((ph % FRAME) != 2 * SLOT + BC + 1) cyc("to_digit2");
      en = 1'b0;
      repeat (4) cyc("disabled");
      en = 1'b1;
      repeat (30) cyc("restart");

      // 5. Zero blank-phase instance
      en = 1'b0;
      cyc("off");
      wr_en = 1'b1;
      wr_data = 16'h8765;
      wr_dp = 4'b0001;
      cyc("wr8765");
      wr_en = 1'b0;
      cyc("commit8765");
      en0 = 1'b1;
      for (int k = 0; k < 2 * DC * ND; k++) begin
         int dg;
         logic [15:0] v;
         v = 16'h8765;
         dg = (k / DC) % ND;
         cyc("idle_t5");
         check("noblank", "sel", {12'h0, sel0}, {12'h0, ~(4'b0001 << dg)});
         check("noblank", "blank", {15'h0, blank0}, 16'h0);
         check("noblank", "nibble", {12'h0, nib0}, (v >> (4 * dg)) & 16'h000f);
         check("noblank", "dp", {15'h0, dp0}, {15'h0, dg == 0});
         check("noblank", "frame_done", {15'h0, fd0}, {15'h0, (k % (DC * ND)) == DC * ND - 1});
      end
      en0 = 1'b0;

      // 6. Leading-zero patterns (hidden only when the macro is defined)
      wr_en = 1'b1;
      wr_data = 16'h0050;
      wr_dp = 4'b1111;
      cyc("wr0050");
      wr_en = 1'b0;
      cyc("commit0050");
      en = 1'b1;
      repeat (FRAME) cyc("lz0050");
      en = 1'b0;
      cyc("off2");
      wr_en = 1'b1;
      wr_data = 16'h0000;
      wr_dp = 4'b0000;
      cyc("wr0000");
      wr_en = 1'b0;
      cyc("commit0000");
      en = 1'b1;
      repeat (FRAME) cyc("lz0000");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
